// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// registered response buffer per port and the architectural flag register.
module alu_arbiter #(
    parameter int DW  = 16,
    parameter int OPW = 3,
    parameter int FW  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_in1,
    input  logic [DW-1:0]  req0_in2,
    input  logic [OPW-1:0] req0_op,
    input  logic           req0_setf,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_data,
    output logic [FW-1:0]  rsp0_flag,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_in1,
    input  logic [DW-1:0]  req1_in2,
    input  logic [OPW-1:0] req1_op,
    input  logic           req1_setf,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_data,
    output logic [FW-1:0]  rsp1_flag,
    output logic [DW-1:0]  ALU_in1,
    output logic [DW-1:0]  ALU_in2,
    output logic [OPW-1:0] op,
    input  logic [DW-1:0]  ALU_out,
    input  logic [FW-1:0]  flag,
    input  logic [FW-1:0]  flag_write,
    output logic [FW-1:0]  flag_reg
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t     state0_r, state1_r;
    buf_state_t     state0_nxt_s, state1_nxt_s;
    logic           last_grant_r;
    logic           elig0_s, elig1_s;
    logic           grant0_s, grant1_s;
    logic [DW-1:0]  data0_r, data1_r;
    logic [FW-1:0]  flag0_r, flag1_r;
    logic [FW-1:0]  flag_reg_r;

    // Bits selected by the mask take the new value; the rest keep their old value.
    function automatic logic [FW-1:0] merge_flags(input logic [FW-1:0] cur,
                                                  input logic [FW-1:0] upd,
                                                  input logic [FW-1:0] mask);
        return (cur & ~mask) | (upd & mask);
    endfunction

    // A granted buffer always ends FULL; an ungranted full buffer empties once drained.
    function automatic buf_state_t buf_next(input buf_state_t cur,
                                            input logic       grant,
                                            input logic       drain);
        buf_state_t nxt;
        case (cur)
            EMPTY:   nxt = grant ? FULL : EMPTY;
            FULL:    nxt = (grant || !drain) ? FULL : EMPTY;
            default: nxt = EMPTY;
        endcase
        return nxt;
    endfunction

    // Eligibility and round-robin grant; a reset cycle grants nobody.
    always_comb begin
        elig0_s  = req0_valid && ((state0_r == EMPTY) || rsp0_ready);
        elig1_s  = req1_valid && ((state1_r == EMPTY) || rsp1_ready);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (elig0_s && elig1_s) begin
            grant0_s = last_grant_r;
            grant1_s = !last_grant_r;
        end else begin
            grant0_s = elig0_s;
            grant1_s = elig1_s;
        end
    end

    // ALU operand mux; idle ALU sees all zeros.
    always_comb begin
        ALU_in1 = {DW{1'b0}};
        ALU_in2 = {DW{1'b0}};
        op      = {OPW{1'b0}};
        if (grant0_s) begin
            ALU_in1 = req0_in1;
            ALU_in2 = req0_in2;
            op      = req0_op;
        end else if (grant1_s) begin
            ALU_in1 = req1_in1;
            ALU_in2 = req1_in2;
            op      = req1_op;
        end else begin
            ALU_in1 = {DW{1'b0}};
            ALU_in2 = {DW{1'b0}};
            op      = {OPW{1'b0}};
        end
    end

    // Response buffer next-state for both ports.
    always_comb begin
        state0_nxt_s = buf_next(state0_r, grant0_s, rsp0_ready);
        state1_nxt_s = buf_next(state1_r, grant1_s, rsp1_ready);
    end

    // State, response capture, round-robin pointer and flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state0_r     <= EMPTY;
            state1_r     <= EMPTY;
            last_grant_r <= 1'b1;
            data0_r      <= {DW{1'b0}};
            data1_r      <= {DW{1'b0}};
            flag0_r      <= {FW{1'b0}};
            flag1_r      <= {FW{1'b0}};
            flag_reg_r   <= {FW{1'b0}};
        end else begin
            state0_r <= state0_nxt_s;
            state1_r <= state1_nxt_s;
            if (grant0_s) begin
                data0_r      <= ALU_out;
                flag0_r      <= flag;
                last_grant_r <= 1'b0;
            end else if (grant1_s) begin
                data1_r      <= ALU_out;
                flag1_r      <= flag;
                last_grant_r <= 1'b1;
            end
            // Only one port is granted per cycle, so the flag write never conflicts.
            if ((grant0_s && req0_setf) || (grant1_s && req1_setf)) begin
                flag_reg_r <= merge_flags(flag_reg_r, flag, flag_write);
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = (state0_r == FULL);
    assign rsp1_valid = (state1_r == FULL);
    assign rsp0_data  = data0_r;
    assign rsp1_data  = data1_r;
    assign rsp0_flag  = flag0_r;
    assign rsp1_flag  = flag1_r;
    assign flag_reg   = flag_reg_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset corner case,
// then randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int DW  = 16;
    localparam int OPW = 3;
    localparam int FW  = 3;

    logic clk = 1'b0;
    logic rst;
    logic           tv[2], tr[2], ts[2];
    logic [DW-1:0]  ta[2], tb_[2];
    logic [OPW-1:0] to[2];
    logic [FW-1:0]  alu_fw;

    logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0]  rsp0_data, rsp1_data, ALU_in1, ALU_in2, ALU_out;
    logic [FW-1:0]  rsp0_flag, rsp1_flag, flag, flag_write, flag_reg;
    logic [OPW-1:0] op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW), .OPW(OPW), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(tv[0]), .req0_ready(req0_ready), .req0_in1(ta[0]), .req0_in2(tb_[0]),
        .req0_op(to[0]), .req0_setf(ts[0]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(tr[0]), .rsp0_data(rsp0_data), .rsp0_flag(rsp0_flag),
        .req1_valid(tv[1]), .req1_ready(req1_ready), .req1_in1(ta[1]), .req1_in2(tb_[1]),
        .req1_op(to[1]), .req1_setf(ts[1]),
        .rsp1_valid(rsp1_valid), .rsp1_ready(tr[1]), .rsp1_data(rsp1_data), .rsp1_flag(rsp1_flag),
        .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .op(op),
        .ALU_out(ALU_out), .flag(flag), .flag_write(flag_write), .flag_reg(flag_reg)
    );

    // Bench ALU: returns {N, C, Z, result}; C is carry for ADD and borrow for SUB.
    function automatic logic [FW+DW-1:0] alu_fn(input logic [OPW-1:0] o,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] w;
        case (o)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} - {1'b0, b};
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        return {w[DW-1], w[DW], (w[DW-1:0] == 16'h0000), w[DW-1:0]};
    endfunction

    always_comb {flag, ALU_out} = alu_fn(op, ALU_in1, ALU_in2);
    assign flag_write = alu_fw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic v0, v1, r0, r1;
        logic [15:0] a0, b0; logic [2:0] o0; logic s0;
        logic [15:0] a1, b1; logic [2:0] o1; logic s1;
        logic [2:0] fw;
        logic e_rdy0, e_rdy1;
        logic e_rv0; logic [15:0] e_rd0; logic [2:0] e_rf0;
        logic e_rv1; logic [15:0] e_rd1; logic [2:0] e_rf1;
        logic [2:0] e_freg;
    } vec_t;

    function automatic vec_t mk(
        logic v0, logic v1, logic r0, logic r1,
        logic [15:0] a0, logic [15:0] b0, logic [2:0] o0, logic s0,
        logic [15:0] a1, logic [15:0] b1, logic [2:0] o1, logic s1, logic [2:0] fw,
        logic e_rdy0, logic e_rdy1,
        logic e_rv0, logic [15:0] e_rd0, logic [2:0] e_rf0,
        logic e_rv1, logic [15:0] e_rd1, logic [2:0] e_rf1, logic [2:0] e_freg);
        vec_t t;
        t.v0 = v0; t.v1 = v1; t.r0 = r0; t.r1 = r1;
        t.a0 = a0; t.b0 = b0; t.o0 = o0; t.s0 = s0;
        t.a1 = a1; t.b1 = b1; t.o1 = o1; t.s1 = s1; t.fw = fw;
        t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1;
        t.e_rv0 = e_rv0; t.e_rd0 = e_rd0; t.e_rf0 = e_rf0;
        t.e_rv1 = e_rv1; t.e_rd1 = e_rd1; t.e_rf1 = e_rf1; t.e_freg = e_freg;
        return t;
    endfunction

    task automatic set_port(input int p, input logic v, input logic r, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] o, input logic s);
        tv[p] = v; tr[p] = r; ta[p] = a; tb_[p] = b; to[p] = o; ts[p] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        alu_fw = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[13];

    // Transaction-level reference model state for the random phase.
    logic           m_valid[2];
    logic [DW-1:0]  m_data[2];
    logic [FW-1:0]  m_flag[2];
    int             m_last;
    logic [FW-1:0]  m_freg;
    logic           hold[2];

    initial begin
        //            v0 v1 r0 r1 a0     b0     o0 s0 a1     b1     o1 s1 fw      rdy0 rdy1 rv0 rd0    rf0     rv1 rd1    rf1     freg
        tbl[0]  = mk(1, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd0, 1, 16'h0005, 16'h0003, 3'd2, 0, 3'b001, 1, 0, 1, 16'h0000, 3'b011, 0, 16'h0000, 3'b000, 3'b001);
        tbl[1]  = mk(0, 1, 1, 1, 16'h0000, 16'h0000, 3'd0, 0, 16'h0005, 16'h0003, 3'd2, 0, 3'b001, 0, 1, 0, 16'h0000, 3'b011, 1, 16'h0001, 3'b000, 3'b001);
        tbl[2]  = mk(1, 0, 1, 1, 16'h0001, 16'h0002, 3'd0, 1, 16'h0000, 16'h0000, 3'd0, 0, 3'b110, 1, 0, 1, 16'h0003, 3'b000, 0, 16'h0001, 3'b000, 3'b001);
        tbl[3]  = mk(1, 0, 1, 1, 16'h0001, 16'h0002, 3'd1, 1, 16'h0000, 16'h0000, 3'd0, 0, 3'b100, 1, 0, 1, 16'hFFFF, 3'b110, 0, 16'h0001, 3'b000, 3'b101);
        tbl[4]  = mk(1, 1, 1, 1, 16'h00F0, 16'h0F0F, 3'd4, 0, 16'h1200, 16'h0034, 3'd3, 0, 3'b111, 0, 1, 0, 16'hFFFF, 3'b110, 1, 16'h1234, 3'b000, 3'b101);
        tbl[5]  = mk(1, 1, 1, 1, 16'h00F0, 16'h0F0F, 3'd4, 0, 16'h0001, 16'h0002, 3'd3, 0, 3'b111, 1, 0, 1, 16'h0FFF, 3'b000, 0, 16'h1234, 3'b000, 3'b101);
        tbl[6]  = mk(1, 1, 1, 1, 16'h0003, 16'h0001, 3'd4, 0, 16'h0001, 16'h0002, 3'd3, 0, 3'b111, 0, 1, 0, 16'h0FFF, 3'b000, 1, 16'h0003, 3'b000, 3'b101);
        tbl[7]  = mk(1, 1, 1, 1, 16'h0003, 16'h0001, 3'd4, 0, 16'hFFFF, 16'h00FF, 3'd2, 0, 3'b111, 1, 0, 1, 16'h0002, 3'b000, 0, 16'h0003, 3'b000, 3'b101);
        tbl[8]  = mk(0, 1, 1, 1, 16'h0000, 16'h0000, 3'd0, 0, 16'hFFFF, 16'h00FF, 3'd2, 0, 3'b111, 0, 1, 0, 16'h0002, 3'b000, 1, 16'h00FF, 3'b000, 3'b101);
        tbl[9]  = mk(1, 1, 1, 0, 16'h0010, 16'h0020, 3'd0, 0, 16'h0100, 16'h0001, 3'd3, 0, 3'b111, 1, 0, 1, 16'h0030, 3'b000, 1, 16'h00FF, 3'b000, 3'b101);
        tbl[10] = mk(1, 1, 1, 0, 16'h0020, 16'h0020, 3'd0, 0, 16'h0100, 16'h0001, 3'd3, 0, 3'b111, 1, 0, 1, 16'h0040, 3'b000, 1, 16'h00FF, 3'b000, 3'b101);
        tbl[11] = mk(1, 1, 1, 1, 16'h0000, 16'h0001, 3'd1, 0, 16'h0100, 16'h0001, 3'd3, 0, 3'b111, 0, 1, 0, 16'h0040, 3'b000, 1, 16'h0101, 3'b000, 3'b101);
        tbl[12] = mk(1, 0, 1, 1, 16'h0000, 16'h0001, 3'd1, 0, 16'h0000, 16'h0000, 3'd0, 0, 3'b111, 1, 0, 1, 16'hFFFF, 3'b110, 0, 16'h0101, 3'b000, 3'b101);

        do_reset();
        chk("reset rsp0_valid", rsp0_valid, 1'b0);
        chk("reset rsp1_valid", rsp1_valid, 1'b0);
        chk("reset rsp0_data", rsp0_data, 16'h0000);
        chk("reset rsp1_flag", rsp1_flag, 3'b000);
        chk("reset flag_reg", flag_reg, 3'b000);

        for (int i = 0; i < 13; i++) begin
            set_port(0, tbl[i].v0, tbl[i].r0, tbl[i].a0, tbl[i].b0, tbl[i].o0, tbl[i].s0);
            set_port(1, tbl[i].v1, tbl[i].r1, tbl[i].a1, tbl[i].b1, tbl[i].o1, tbl[i].s1);
            alu_fw = tbl[i].fw;
            #1;
            chk($sformatf("vec%0d req0_ready", i), req0_ready, tbl[i].e_rdy0);
            chk($sformatf("vec%0d req1_ready", i), req1_ready, tbl[i].e_rdy1);
            @(negedge clk);
            chk($sformatf("vec%0d rsp0_valid", i), rsp0_valid, tbl[i].e_rv0);
            chk($sformatf("vec%0d rsp0_data", i), rsp0_data, tbl[i].e_rd0);
            chk($sformatf("vec%0d rsp0_flag", i), rsp0_flag, tbl[i].e_rf0);
            chk($sformatf("vec%0d rsp1_valid", i), rsp1_valid, tbl[i].e_rv1);
            chk($sformatf("vec%0d rsp1_data", i), rsp1_data, tbl[i].e_rd1);
            chk($sformatf("vec%0d rsp1_flag", i), rsp1_flag, tbl[i].e_rf1);
            chk($sformatf("vec%0d flag_reg", i), flag_reg, tbl[i].e_freg);
        end

        // Reset lands while port 0 holds a result and port 1 would be granted with setf.
        rst = 1'b1;
        set_port(0, 1'b1, 1'b1, 16'h8000, 16'h8000, 3'd0, 1'b1);
        set_port(1, 1'b1, 1'b1, 16'h8000, 16'h8000, 3'd0, 1'b1);
        alu_fw = 3'b111;
        @(negedge clk);
        chk("midreset rsp0_valid", rsp0_valid, 1'b0);
        chk("midreset rsp1_valid", rsp1_valid, 1'b0);
        chk("midreset rsp0_data", rsp0_data, 16'h0000);
        chk("midreset flag_reg", flag_reg, 3'b000);
        rst = 1'b0;
        #1;
        chk("postreset req0_ready", req0_ready, 1'b1);
        chk("postreset req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        chk("postreset rsp0_data", rsp0_data, 16'h0000);
        chk("postreset flag_reg", flag_reg, 3'b011);

        // Randomized phase with the reference model.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0; m_data[p] = 16'h0; m_flag[p] = 3'b000; hold[p] = 1'b0;
        end
        m_last = 1;
        m_freg = 3'b000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int g;
            logic e[2];
            logic [FW+DW-1:0] res;
            rst = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    set_port(p, ($urandom_range(0, 3) != 0), 1'b0, 16'($urandom), 16'($urandom),
                             3'($urandom_range(0, 7)), 1'($urandom));
                end
                tr[p] = ($urandom_range(0, 3) != 0);
            end
            alu_fw = 3'($urandom);
            #1;
            g = -1;
            for (int p = 0; p < 2; p++) e[p] = tv[p] && (!m_valid[p] || tr[p]);
            if (e[0] && e[1]) g = (m_last == 0) ? 1 : 0;
            else if (e[0]) g = 0;
            else if (e[1]) g = 1;
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    m_valid[p] = 1'b0; m_data[p] = 16'h0; m_flag[p] = 3'b000;
                end
                m_last = 1;
                m_freg = 3'b000;
            end else begin
                chk($sformatf("rnd%0d req0_ready", cyc), req0_ready, (g == 0));
                chk($sformatf("rnd%0d req1_ready", cyc), req1_ready, (g == 1));
                chk($sformatf("rnd%0d ALU_in1", cyc), ALU_in1, (g < 0) ? 16'h0 : ta[g]);
                chk($sformatf("rnd%0d ALU_in2", cyc), ALU_in2, (g < 0) ? 16'h0 : tb_[g]);
                chk($sformatf("rnd%0d op", cyc), op, (g < 0) ? 3'd0 : to[g]);
                for (int p = 0; p < 2; p++) begin
                    if (g == p) begin
                        res = alu_fn(to[p], ta[p], tb_[p]);
                        m_valid[p] = 1'b1;
                        m_data[p] = res[DW-1:0];
                        m_flag[p] = res[FW+DW-1:DW];
                        m_last = p;
                        if (ts[p]) m_freg = (m_freg & ~alu_fw) | (m_flag[p] & alu_fw);
                    end else if (tr[p]) begin
                        m_valid[p] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) hold[p] = tv[p] && (g != p) && !rst;
            @(negedge clk);
            chk($sformatf("rnd%0d rsp0_valid", cyc), rsp0_valid, m_valid[0]);
            chk($sformatf("rnd%0d rsp0_data", cyc), rsp0_data, m_data[0]);
            chk($sformatf("rnd%0d rsp0_flag", cyc), rsp0_flag, m_flag[0]);
            chk($sformatf("rnd%0d rsp1_valid", cyc), rsp1_valid, m_valid[1]);
            chk($sformatf("rnd%0d rsp1_data", cyc), rsp1_data, m_data[1]);
            chk($sformatf("rnd%0d rsp1_flag", cyc), rsp1_flag, m_flag[1]);
            chk($sformatf("rnd%0d flag_reg", cyc), flag_reg, m_freg);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
